// File: rtl/shift_cmd_pkg.sv
// Shared definitions for the shift_reg command sequencer: the shift_reg
// op-code values and the sequencer state encoding.
package shift_cmd_pkg;

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_LSR  = 3'b010;
   localparam logic [2:0] OP_LSL  = 3'b011;
   localparam logic [2:0] OP_ASR  = 3'b100;
   localparam logic [2:0] OP_SIN  = 3'b101;
   localparam logic [2:0] OP_ROR  = 3'b110;
   localparam logic [2:0] OP_ROL  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/shift_model.sv
// Combinational next-value of a shift_reg for one enabled step.
// Serial-in shifts right and enters the new bit at the MSB.
// Only instantiated when SHIFT_CMD_SEQ_MODEL_EN is defined.
module shift_model
   import shift_cmd_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [2:0]   op_i,
   input  logic [N-1:0] cur_i,
   input  logic [N-1:0] data_i,
   input  logic         instream_i,
   output logic [N-1:0] next_o
);

   // Select the register value produced by each op code
   always_comb begin
      next_o = cur_i;
      case (op_i)
         OP_CLR:  next_o = '0;
         OP_LOAD: next_o = data_i;
         OP_LSR:  next_o = {1'b0, cur_i[N-1:1]};
         OP_LSL:  next_o = {cur_i[N-2:0], 1'b0};
         OP_ASR:  next_o = {cur_i[N-1], cur_i[N-1:1]};
         OP_SIN:  next_o = {instream_i, cur_i[N-1:1]};
         OP_ROR:  next_o = {cur_i[0], cur_i[N-1:1]};
         OP_ROL:  next_o = {cur_i[N-2:0], cur_i[N-1]};
         default: next_o = cur_i;
      endcase
   end

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer feeding shift_reg. One command per valid/ready
// handshake is expanded into a run of consecutive enabled steps; the
// last step accepts the next command so runs can follow with no bubble.
// Optional macro SHIFT_CMD_SEQ_MODEL_EN adds a shadow model of shift_reg
// and a sticky mismatch flag comparing it with sr_data_out.
module shift_cmd_seq
   import shift_cmd_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic [CNT_W-1:0]    cmd_cnt,
   input  logic [N-1:0]        cmd_data,
   input  logic [2**CNT_W-1:0] cmd_bits,
   output logic                sr_en,
   output logic [2:0]          sr_ctrl,
   output logic [N-1:0]        sr_data_in,
   output logic                sr_instream,
   output logic                busy,
   output logic                done
`ifdef SHIFT_CMD_SEQ_MODEL_EN
   ,
   input  logic [N-1:0]        sr_data_out,
   output logic                mismatch
`endif
);

   localparam int BITS_W = 2**CNT_W;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [N-1:0]        data_q, data_d;
   logic [BITS_W-1:0]   bits_q, bits_d;
   logic [CNT_W-1:0]    last_q, last_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic                accept;
   logic                lastStep;

   // Drive shift_reg from the held command while running, and decide
   // whether to advance, finish, or reload from a new handshake
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      bits_d      = bits_q;
      last_d      = last_q;
      idx_d       = idx_q;
      cmd_ready   = 1'b0;
      sr_en       = 1'b0;
      sr_ctrl     = OP_CLR;
      sr_data_in  = '0;
      sr_instream = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      lastStep    = 1'b0;
      accept      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = !rst;
         end
         ST_RUN: begin
            sr_en       = 1'b1;
            sr_ctrl     = op_q;
            sr_data_in  = data_q;
            sr_instream = (op_q == OP_SIN) ? bits_q[idx_q] : 1'b0;
            busy        = 1'b1;
            lastStep    = (idx_q == last_q);
            done        = lastStep && !rst;
            cmd_ready   = lastStep && !rst;
            if (lastStep) begin
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      accept = cmd_valid && cmd_ready;
      if (accept) begin
         op_d    = cmd_op;
         data_d  = cmd_data;
         bits_d  = cmd_bits;
         last_d  = (cmd_op == OP_CLR || cmd_op == OP_LOAD) ? '0 : cmd_cnt;
         idx_d   = '0;
         state_d = ST_RUN;
      end
   end

   // State and command registers; reset discards any partial command
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_CLR;
         data_q  <= '0;
         bits_q  <= '0;
         last_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         bits_q  <= bits_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
      end
   end

`ifdef SHIFT_CMD_SEQ_MODEL_EN
   logic [N-1:0] model_q;
   logic [N-1:0] modelNext;
   logic         check_q;
   logic         mismatch_q;

   shift_model #(.N(N)) u_model (
      .op_i       (sr_ctrl),
      .cur_i      (model_q),
      .data_i     (sr_data_in),
      .instream_i (sr_instream),
      .next_o     (modelNext)
   );

   // Track shift_reg in a shadow register and flag the first disagreement
   // seen the cycle after an enabled step; the flag holds until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         model_q    <= '0;
         check_q    <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         if (sr_en) begin
            model_q <= modelNext;
         end
         check_q <= sr_en;
         if (check_q && (model_q != sr_data_out)) begin
            mismatch_q <= 1'b1;
         end
      end
   end

   assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Testbench for shift_cmd_seq: directed vector table, random traffic
// against a queue-based step model, and (with SHIFT_CMD_SEQ_MODEL_EN)
// a check of the sticky mismatch flag.
module tb_shift_cmd_seq;

   localparam int N     = 4;
   localparam int CNT_W = 3;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic [2:0] op;
      logic [2:0] cnt;
      logic [3:0] data;
      logic [7:0] bits;
      logic       en;
      logic [2:0] ctrl;
      logic [3:0] din;
      logic       ins;
      logic       busy;
      logic       done;
      logic       ready;
   } vec_t;

   typedef struct {
      logic [2:0] op;
      logic [3:0] data;
      logic       ins;
   } stepRec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmdValid;
   logic       cmdReady;
   logic [2:0] cmdOp;
   logic [2:0] cmdCnt;
   logic [3:0] cmdData;
   logic [7:0] cmdBits;
   logic       srEn;
   logic [2:0] srCtrl;
   logic [3:0] srDataIn;
   logic       srInstream;
   logic       busy;
   logic       done;
   logic [3:0] tbReg;
`ifdef SHIFT_CMD_SEQ_MODEL_EN
   logic [3:0] corruptMask = 4'h0;
   logic [3:0] srDataOut;
   logic       mismatch;
   assign srDataOut = tbReg ^ corruptMask;
`endif

   int passCount  = 0;
   int checkCount = 0;
   vec_t     table_v[$];
   stepRec_t pend[$];

   shift_cmd_seq #(.N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmdValid),
      .cmd_ready   (cmdReady),
      .cmd_op      (cmdOp),
      .cmd_cnt     (cmdCnt),
      .cmd_data    (cmdData),
      .cmd_bits    (cmdBits),
      .sr_en       (srEn),
      .sr_ctrl     (srCtrl),
      .sr_data_in  (srDataIn),
      .sr_instream (srInstream),
      .busy        (busy),
      .done        (done)
`ifdef SHIFT_CMD_SEQ_MODEL_EN
      ,
      .sr_data_out (srDataOut),
      .mismatch    (mismatch)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Shift register contents after one step, from the op definitions
   function automatic logic [3:0] shiftRef(input logic [2:0] op, input logic [3:0] cur,
                                           input logic [3:0] din, input logic ins);
      case (op)
         3'd0: return 4'h0;
         3'd1: return din;
         3'd2: return cur >> 1;
         3'd3: return cur << 1;
         3'd4: return 4'($signed(cur) >>> 1);
         3'd5: return (4'(ins) << 3) | (cur >> 1);
         3'd6: return (cur >> 1) | (cur << 3);
         default: return (cur << 1) | (cur >> 3);
      endcase
   endfunction

   // Stand-in for the downstream shift_reg, driven by the sequencer outputs
   always @(posedge clk) begin
      if (rst) tbReg <= 4'h0;
      else if (srEn) tbReg <= shiftRef(srCtrl, tbReg, srDataIn, srInstream);
   end

   function automatic vec_t mk(input logic r, input logic v, input logic [2:0] op,
                               input logic [2:0] cnt, input logic [3:0] data,
                               input logic [7:0] bits, input logic en,
                               input logic [2:0] ctrl, input logic [3:0] din,
                               input logic ins, input logic bsy, input logic dn,
                               input logic rdy);
      vec_t x;
      x = {r, v, op, cnt, data, bits, en, ctrl, din, ins, bsy, dn, rdy};
      return x;
   endfunction

   task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst      = v.rst;
      cmdValid = v.valid;
      cmdOp    = v.op;
      cmdCnt   = v.cnt;
      cmdData  = v.data;
      cmdBits  = v.bits;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      checkField({tag, ".sr_en"},       8'(srEn),       8'(v.en));
      checkField({tag, ".sr_ctrl"},     8'(srCtrl),     8'(v.ctrl));
      checkField({tag, ".sr_data_in"},  8'(srDataIn),   8'(v.din));
      checkField({tag, ".sr_instream"}, 8'(srInstream), 8'(v.ins));
      checkField({tag, ".busy"},        8'(busy),       8'(v.busy));
      checkField({tag, ".done"},        8'(done),       8'(v.done));
      checkField({tag, ".cmd_ready"},   8'(cmdReady),   8'(v.ready));
   endtask

   task automatic runCycle(input vec_t v, input bit chk, input string tag);
      @(negedge clk);
      applyStimulus(v);
      #1;
      if (chk) checkOutput(v, tag);
      @(posedge clk);
   endtask

   // Expected outputs from the queue of steps still owed to shift_reg
   function automatic vec_t modelExpect(input vec_t v);
      vec_t e;
      e = v;
      e.en = 1'b0; e.ctrl = 3'd0; e.din = 4'd0; e.ins = 1'b0; e.busy = 1'b0;
      if (pend.size() > 0) begin
         e.en   = 1'b1;
         e.ctrl = pend[0].op;
         e.din  = pend[0].data;
         e.ins  = pend[0].ins;
         e.busy = 1'b1;
      end
      e.ready = !v.rst && (pend.size() <= 1);
      e.done  = !v.rst && (pend.size() == 1);
      return e;
   endfunction

   task automatic modelAdvance(input vec_t e);
      int n;
      stepRec_t s;
      if (e.rst) begin
         pend.delete();
      end else begin
         if (pend.size() > 0) void'(pend.pop_front());
         if (e.valid && e.ready) begin
            n = (e.op <= 3'd1) ? 1 : int'(e.cnt) + 1;
            for (int i = 0; i < n; i++) begin
               s.op   = e.op;
               s.data = e.data;
               s.ins  = (e.op == 3'd5) ? e.bits[i] : 1'b0;
               pend.push_back(s);
            end
         end
      end
   endtask

   initial begin
      vec_t v, e;
      rst = 1'b1; cmdValid = 1'b0; cmdOp = 3'd0; cmdCnt = 3'd0; cmdData = 4'd0; cmdBits = 8'd0;

      // reset: first cycle unchecked, second checks reset outputs
      runCycle(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0), 1'b0, "rst0");
      runCycle(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0), 1'b1, "rst1");

      // load ignores cnt
      table_v.push_back(mk(0,1,3'b001,3'd5,4'b1010,8'h00, 0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b001,4'b1010,0,1,1,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      0,3'd0,4'h0,0,0,0,1));
      // ror three steps
      table_v.push_back(mk(0,1,3'b110,3'd2,4'b0011,8'h00, 0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b110,4'b0011,0,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b110,4'b0011,0,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b110,4'b0011,0,1,1,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      0,3'd0,4'h0,0,0,0,1));
      // clear (cnt ignored), then serial stream 1,0,1,0
      table_v.push_back(mk(0,1,3'b000,3'd3,4'h0,8'h00,    0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b000,4'h0,0,1,1,1));
      table_v.push_back(mk(0,1,3'b101,3'd3,4'h0,8'h05,    0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b101,4'h0,1,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b101,4'h0,0,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b101,4'h0,1,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b101,4'h0,0,1,1,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      0,3'd0,4'h0,0,0,0,1));
      // back-to-back: second command held valid, taken on the last step
      table_v.push_back(mk(0,1,3'b010,3'd1,4'b1111,8'h00, 0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,1,3'b011,3'd0,4'b0110,8'h00, 1,3'b010,4'b1111,0,1,0,0));
      table_v.push_back(mk(0,1,3'b011,3'd0,4'b0110,8'h00, 1,3'b010,4'b1111,0,1,1,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b011,4'b0110,0,1,1,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      0,3'd0,4'h0,0,0,0,1));
      // reset at step 3 of an eight-step run, then a fresh command
      table_v.push_back(mk(0,1,3'b010,3'd7,4'b1001,8'h00, 0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b010,4'b1001,0,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b010,4'b1001,0,1,0,0));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b010,4'b1001,0,1,0,0));
      table_v.push_back(mk(1,0,3'd0,3'd0,4'h0,8'h00,      1,3'b010,4'b1001,0,1,0,0));
      table_v.push_back(mk(0,1,3'b111,3'd0,4'b0001,8'h00, 0,3'd0,4'h0,0,0,0,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      1,3'b111,4'b0001,0,1,1,1));
      table_v.push_back(mk(0,0,3'd0,3'd0,4'h0,8'h00,      0,3'd0,4'h0,0,0,0,1));

      for (int i = 0; i < table_v.size(); i++) begin
         runCycle(table_v[i], 1'b1, $sformatf("vec%0d", i));
         if (i == 15) checkField("serial_result", 8'(tbReg), 8'h05);
      end

      // random traffic against the step-queue model
      pend.delete();
      for (int c = 0; c < 600; c++) begin
         v.rst   = ($urandom_range(0, 49) == 0);
         v.valid = ($urandom_range(0, 9) < 6);
         v.op    = 3'($urandom);
         v.cnt   = 3'($urandom);
         v.data  = 4'($urandom);
         v.bits  = 8'($urandom);
         e = modelExpect(v);
         @(negedge clk);
         applyStimulus(e);
         #1;
         checkOutput(e, $sformatf("rnd%0d", c));
         @(posedge clk);
         modelAdvance(e);
      end

`ifdef SHIFT_CMD_SEQ_MODEL_EN
      // drain, then force one bad sr_data_out after a load step
      for (int c = 0; c < 10; c++) runCycle(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0), 1'b0, "drain");
      runCycle(mk(0,1,3'b001,3'd0,4'b0011,8'h00, 0,0,0,0,0,0,0), 1'b0, "mload");
      runCycle(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0), 1'b0, "mstep");
      #1;
      checkField("mismatch_clean", 8'(mismatch), 8'h00);
      @(negedge clk);
      corruptMask = 4'h1;
      @(posedge clk);
      #1;
      corruptMask = 4'h0;
      checkField("mismatch_set", 8'(mismatch), 8'h01);
      for (int c = 0; c < 4; c++) runCycle(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0), 1'b0, "mhold");
      #1;
      checkField("mismatch_sticky", 8'(mismatch), 8'h01);
      runCycle(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0), 1'b0, "mrst");
      #1;
      checkField("mismatch_cleared", 8'(mismatch), 8'h00);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
